// File: rtl/rcv25_pkg.sv
// ---------------------------------------------------------------------------
// rcv25_pkg : shared types and constants for the 25 MHz receive read engine
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rcv25_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

  localparam int SKID_DEPTH = 2;

endpackage

`default_nettype wire

// File: rtl/rcv25_read_engine_if.sv
// ---------------------------------------------------------------------------
// rcv25_read_engine_if : FIFO read port plus valid/ready output stream
// Revision             : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface rcv25_read_engine_if #(
  parameter int DW = 32
);
  logic          fifo_empty;
  logic          rd_25;
  logic [DW-1:0] fifo_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] rdata;

  modport master (
    input  fifo_empty, fifo_rdata, out_ready,
    output rd_25, out_valid, rdata
  );

  modport slave (
    output fifo_empty, fifo_rdata, out_ready,
    input  rd_25, out_valid, rdata
  );
endinterface

`default_nettype wire

// File: rtl/rcv25_skid_buf.sv
// ---------------------------------------------------------------------------
// rcv25_skid_buf : two-entry in-order skid buffer; head is a plain register
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rcv25_skid_buf
  import rcv25_pkg::*;
#(
  parameter int DW = 32
) (
  input  wire logic          clk,
  input  wire logic          reset_n,
  input  wire logic          push,
  input  wire logic [DW-1:0] push_data,
  input  wire logic          pop,
  output logic      [DW-1:0] head,
  output logic      [1:0]    occ
);

  logic [DW-1:0] tail;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head <= '0;
      tail <= '0;
      occ  <= 2'd0;
    end else begin
      assert (!(push && !pop && occ == 2'(SKID_DEPTH)));
      assert (!(pop && occ == 2'd0));
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) head <= push_data;
          else             tail <= push_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          // occupancy unchanged: head advances, new word lands behind it
          if (occ == 2'd1) begin
            head <= push_data;
          end else begin
            head <= tail;
            tail <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/rcv25_read_engine.sv
// ---------------------------------------------------------------------------
// rcv25_read_engine : credit-limited FIFO drain into a skid buffer with stats
// Revision          : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rcv25_read_engine
  import rcv25_pkg::*;
#(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  wire logic             clk_rcv25,
  input  wire logic             reset_n,
  input  wire logic             enable,
  input  wire logic             clr_stats,
  output logic                  busy,
  output logic      [CNT_W-1:0] rd_count,
  output logic      [DW-1:0]    rd_chksum,
  rcv25_read_engine_if.master   bus
);

  rd_state_e  state;
  logic       inflight;
  logic [1:0] occ;
  logic       pop;
  logic [2:0] credit;

  assign pop    = bus.out_valid & bus.out_ready;
  // words already committed to the buffer once this cycle settles
  assign credit = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

  assign bus.rd_25     = (state == RUN) && !bus.fifo_empty && (credit < 3'd2);
  assign bus.out_valid = (occ != 2'd0);

  always_ff @(posedge clk_rcv25 or negedge reset_n) begin
    if (!reset_n) inflight <= 1'b0;
    else          inflight <= bus.rd_25;
  end

  always_ff @(posedge clk_rcv25 or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (!enable) state <= DRAIN;
        end
        DRAIN: begin
          if (enable) begin
            state <= RUN;
          end else if (!inflight && occ == 2'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_rcv25 or negedge reset_n) begin
    if (!reset_n) begin
      rd_count  <= '0;
      rd_chksum <= '0;
    end else if (pop) begin
      // a clear coinciding with a pop still counts the popped word
      rd_count  <= clr_stats ? CNT_W'(1) : rd_count + CNT_W'(1);
      rd_chksum <= clr_stats ? bus.rdata : rd_chksum ^ bus.rdata;
    end else if (clr_stats) begin
      rd_count  <= '0;
      rd_chksum <= '0;
    end
  end

  rcv25_skid_buf #(
    .DW (DW)
  ) u_skid (
    .clk       (clk_rcv25),
    .reset_n   (reset_n),
    .push      (inflight),
    .push_data (bus.fifo_rdata),
    .pop       (pop),
    .head      (bus.rdata),
    .occ       (occ)
  );

endmodule

`default_nettype wire

// File: tb/tb_rcv25_read_engine.sv
// ---------------------------------------------------------------------------
// tb_rcv25_read_engine : directed self-checking bench for rcv25_read_engine
// Revision             : 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_rcv25_read_engine;

  localparam int DW    = 32;
  localparam int CNT_W = 4;

  logic             clk_rcv25 = 1'b0;
  logic             reset_n   = 1'b1;
  logic             enable    = 1'b0;
  logic             clr_stats = 1'b0;
  logic             busy;
  logic [CNT_W-1:0] rd_count;
  logic [DW-1:0]    rd_chksum;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] got[$];

  rcv25_read_engine_if #(.DW(DW)) bus ();

  rcv25_read_engine #(
    .DW    (DW),
    .CNT_W (CNT_W)
  ) dut (
    .clk_rcv25 (clk_rcv25),
    .reset_n   (reset_n),
    .enable    (enable),
    .clr_stats (clr_stats),
    .busy      (busy),
    .rd_count  (rd_count),
    .rd_chksum (rd_chksum),
    .bus       (bus)
  );

  always #20 clk_rcv25 = ~clk_rcv25;

  // FIFO model: read data appears the cycle after rd_25
  logic [DW-1:0] mem [256];
  logic [7:0]    wp = 8'd0;
  logic [7:0]    rp = 8'd0;

  assign bus.fifo_empty = (rp == wp);

  always @(posedge clk_rcv25) begin
    if (bus.rd_25) begin
      bus.fifo_rdata <= mem[rp];
      rp             <= rp + 8'd1;
    end
  end

  task automatic next();
    @(posedge clk_rcv25);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_rcv25);
    if (bus.out_valid && bus.out_ready) got.push_back(bus.rdata);
  endtask

  task automatic load(input logic [DW-1:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wp] = first + DW'(i);
      wp      = wp + 8'd1;
    end
  endtask

  task automatic flush();
    wp = rp;
  endtask

  task automatic clear_stats();
    next();
    clr_stats = 1'b1;
    sample();
    next();
    clr_stats = 1'b0;
  endtask

  task automatic go_idle(input string name);
    bit done;
    done = 1'b0;
    next();
    enable = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      sample();
      if (!busy) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_idle_timeout: busy=%0b required 0", name, busy);
    end
  endtask

  task automatic test_reset();
    bus.out_ready = 1'b0;
    #5 reset_n = 1'b0;
    #50;
    checks++; if (bus.rd_25 !== 1'b0)     begin errors++; $display("FAIL reset_rd_25: got %0b want 0", bus.rd_25); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid); end
    checks++; if (bus.rdata !== '0)       begin errors++; $display("FAIL reset_rdata: got %h want 0", bus.rdata); end
    checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (rd_count !== '0)        begin errors++; $display("FAIL reset_rd_count: got %0d want 0", rd_count); end
    checks++; if (rd_chksum !== '0)       begin errors++; $display("FAIL reset_rd_chksum: got %h want 0", rd_chksum); end
    next();
    reset_n = 1'b1;
    sample();
  endtask

  task automatic test_streaming();
    logic [15:0]   rdh;
    logic [15:0]   vh;
    logic [DW-1:0] dat [16];
    got.delete();
    flush();
    load(32'h1, 8);
    next();
    enable        = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      sample();
      rdh[c] = bus.rd_25;
      vh[c]  = bus.out_valid;
      dat[c] = bus.rdata;
    end
    checks++; if (rdh !== 16'h01FE) begin errors++; $display("FAIL stream_rd_25_pattern: got %h want 01fe", rdh); end
    checks++; if (vh !== 16'h07F8)  begin errors++; $display("FAIL stream_out_valid_pattern: got %h want 07f8", vh); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (dat[3+k] !== DW'(k + 1)) begin
        errors++;
        $display("FAIL stream_rdata_%0d: got %h want %h", k, dat[3+k], DW'(k + 1));
      end
    end
    checks++; if (rd_count !== 4'd8)     begin errors++; $display("FAIL stream_rd_count: got %0d want 8", rd_count); end
    checks++; if (rd_chksum !== 32'h8)   begin errors++; $display("FAIL stream_rd_chksum: got %h want 8", rd_chksum); end
    go_idle("stream");
  endtask

  task automatic test_backpressure();
    bit found;
    got.delete();
    flush();
    load(32'h1, 8);
    clear_stats();
    enable        = 1'b1;
    bus.out_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      sample();
      if (bus.out_valid) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL bp_first_valid_timeout: out_valid=0 required 1"); end
    next();
    bus.out_ready = 1'b0;
    sample();
    for (int i = 0; i < 3; i++) begin
      sample();
      checks++; if (bus.rd_25 !== 1'b0)     begin errors++; $display("FAIL bp_rd_25_stalled_%0d: got %0b want 0", i, bus.rd_25); end
      checks++; if (bus.rdata !== 32'h2)    begin errors++; $display("FAIL bp_rdata_hold_%0d: got %h want 2", i, bus.rdata); end
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid_%0d: got %0b want 1", i, bus.out_valid); end
    end
    checks++; if (rd_count !== 4'd1) begin errors++; $display("FAIL bp_rd_count_held: got %0d want 1", rd_count); end
    next();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && got.size() < 8; i++) sample();
    checks++; if (got.size() !== 8) begin errors++; $display("FAIL bp_word_total: got %0d want 8", got.size()); end
    for (int k = 0; k < 8 && k < got.size(); k++) begin
      checks++;
      if (got[k] !== DW'(k + 1)) begin
        errors++;
        $display("FAIL bp_order_%0d: got %h want %h", k, got[k], DW'(k + 1));
      end
    end
    go_idle("bp");
  endtask

  task automatic test_enable_drop();
    bit         saw_rd;
    logic [5:0] bh;
    got.delete();
    flush();
    load(32'h1, 8);
    clear_stats();
    enable        = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) sample();
    next();
    enable = 1'b0;
    sample();
    checks++; if (bus.rd_25 !== 1'b1) begin errors++; $display("FAIL drop_rd_25_word5: got %0b want 1", bus.rd_25); end
    saw_rd = 1'b0;
    for (int c = 0; c < 6; c++) begin
      sample();
      bh[c] = busy;
      if (bus.rd_25) saw_rd = 1'b1;
    end
    checks++; if (saw_rd !== 1'b0)   begin errors++; $display("FAIL drop_extra_rd_25: got %0b want 0", saw_rd); end
    checks++; if (bh !== 6'b000111)  begin errors++; $display("FAIL drop_busy_pattern: got %b want 000111", bh); end
    checks++; if (got.size() !== 5)  begin errors++; $display("FAIL drop_word_total: got %0d want 5", got.size()); end
    for (int k = 0; k < 5 && k < got.size(); k++) begin
      checks++;
      if (got[k] !== DW'(k + 1)) begin
        errors++;
        $display("FAIL drop_order_%0d: got %h want %h", k, got[k], DW'(k + 1));
      end
    end
    flush();
  endtask

  task automatic test_counter_wrap();
    bit s15, s16;
    int n;
    got.delete();
    flush();
    load(32'h100, 17);
    clear_stats();
    enable        = 1'b1;
    bus.out_ready = 1'b1;
    s15 = 1'b0;
    s16 = 1'b0;
    for (int i = 0; i < 40 && got.size() < 17; i++) begin
      n = got.size();
      sample();
      if (n == 15 && !s15) begin
        s15 = 1'b1;
        checks++; if (rd_count !== 4'd15) begin errors++; $display("FAIL wrap_at_15: got %0d want 15", rd_count); end
      end
      if (n == 16 && !s16) begin
        s16 = 1'b1;
        checks++; if (rd_count !== 4'd0) begin errors++; $display("FAIL wrap_to_0: got %0d want 0", rd_count); end
      end
    end
    sample();
    checks++; if (!(s15 && s16))     begin errors++; $display("FAIL wrap_points_seen: got %0b%0b want 11", s15, s16); end
    checks++; if (rd_count !== 4'd1) begin errors++; $display("FAIL wrap_final: got %0d want 1", rd_count); end
    checks++; if (got.size() !== 17) begin errors++; $display("FAIL wrap_word_total: got %0d want 17", got.size()); end
    go_idle("wrap");
  endtask

  task automatic test_clr_coincident();
    bit found;
    got.delete();
    flush();
    mem[wp] = 32'h11;       wp = wp + 8'd1;
    mem[wp] = 32'hA5A5A5A5; wp = wp + 8'd1;
    next();
    enable        = 1'b1;
    bus.out_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      sample();
      if (bus.out_valid && bus.rdata == 32'h11) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL clr_first_word_timeout: rdata=%h required 11", bus.rdata); end
    next();
    bus.out_ready = 1'b1;
    sample();
    next();
    clr_stats = 1'b1;
    sample();
    checks++; if (bus.rdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL clr_pop_word: got %h want a5a5a5a5", bus.rdata); end
    next();
    clr_stats     = 1'b0;
    bus.out_ready = 1'b0;
    sample();
    checks++; if (rd_count !== 4'd1)          begin errors++; $display("FAIL clr_pop_count: got %0d want 1", rd_count); end
    checks++; if (rd_chksum !== 32'hA5A5A5A5) begin errors++; $display("FAIL clr_pop_chksum: got %h want a5a5a5a5", rd_chksum); end
    next();
    clr_stats = 1'b1;
    sample();
    next();
    clr_stats = 1'b0;
    sample();
    checks++; if (rd_count !== 4'd0)  begin errors++; $display("FAIL clr_alone_count: got %0d want 0", rd_count); end
    checks++; if (rd_chksum !== '0)   begin errors++; $display("FAIL clr_alone_chksum: got %h want 0", rd_chksum); end
    go_idle("clr");
  endtask

  task automatic test_midstream_reset();
    got.delete();
    flush();
    load(32'h21, 8);
    clear_stats();
    enable        = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10 && got.size() < 1; i++) sample();
    next();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) sample();
    checks++; if (!(bus.out_valid === 1'b1 && bus.rd_25 === 1'b0 && bus.rdata === 32'h22)) begin
      errors++;
      $display("FAIL rst_pre_full: valid=%0b rd=%0b rdata=%h want 1 0 22", bus.out_valid, bus.rd_25, bus.rdata);
    end
    checks++; if (rd_count !== 4'd1) begin errors++; $display("FAIL rst_pre_count: got %0d want 1", rd_count); end
    next();
    reset_n = 1'b0;
    enable  = 1'b0;
    #1;
    checks++; if (bus.rd_25 !== 1'b0)     begin errors++; $display("FAIL rst_rd_25: got %0b want 0", bus.rd_25); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %0b want 0", bus.out_valid); end
    checks++; if (bus.rdata !== '0)       begin errors++; $display("FAIL rst_rdata: got %h want 0", bus.rdata); end
    checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL rst_busy: got %0b want 0", busy); end
    checks++; if (rd_count !== '0)        begin errors++; $display("FAIL rst_rd_count: got %0d want 0", rd_count); end
    checks++; if (rd_chksum !== '0)       begin errors++; $display("FAIL rst_rd_chksum: got %h want 0", rd_chksum); end
    sample();
    next();
    reset_n = 1'b1;
    flush();
    load(32'h77, 2);
    got.delete();
    enable        = 1'b1;
    bus.out_ready = 1'b1;
    sample();
    checks++; if (rd_count !== 4'd0) begin errors++; $display("FAIL rst_restart_count: got %0d want 0", rd_count); end
    for (int i = 0; i < 12 && got.size() < 2; i++) sample();
    sample();
    checks++; if (rd_count !== 4'd2)      begin errors++; $display("FAIL rst_resume_count: got %0d want 2", rd_count); end
    checks++; if (rd_chksum !== 32'h0F)   begin errors++; $display("FAIL rst_resume_chksum: got %h want 0f", rd_chksum); end
    checks++; if (!(got.size() == 2 && got[0] === 32'h77 && got[1] === 32'h78)) begin
      errors++;
      $display("FAIL rst_resume_words: got %0d words want 77 78", got.size());
    end
    go_idle("rst");
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_enable_drop();
    test_counter_wrap();
    test_clr_coincident();
    test_midstream_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
